i2c_subordinate_regfile: RTL and testbench
==========================================

Name: i2c_subordinate_regfile

Overview:
- Parametrised next-generation I2C subordinate (target) for the 400 kHz bus domain.
- Replaces single-byte transfers with multi-byte bursts into an internal NUM_REGS x 8 register file, addressed by a register pointer with auto-increment.
- Also adds repeated-START handling and a host-side port for loading and observing registers.
- Sits between the board-level open-drain SCL/SDA pins and local control logic.

Parameters:
- MY_ADDR, 7'h01, 7-bit bus address this target answers to.
- NUM_REGS, 8, number of 8-bit registers; power of two, 2..256.
- AW, $clog2(NUM_REGS), pointer/host address width (derived; not overridden).

Ports:
- clk_400  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SCL  input  1  bus clock from controller, asynchronous.
- SDA  inout  1  bus data; open-drain: driven 0 or released to Z, never driven 1.
- host_we  input  1  host write strobe into the register file.
- host_addr  input  AW  host write address.
- host_wdata  input  8  host write data.
- reg_rd_addr  input  AW  host read address.
- reg_rd_data  output  8  combinational read of regfile[reg_rd_addr].
- wr_strobe  output  1  one-cycle pulse: a bus-written byte was committed.
- wr_addr  output  AW  register index committed; valid with wr_strobe.
- wr_data  output  8  byte committed; valid with wr_strobe.
- rd_strobe  output  1  one-cycle pulse: a register was loaded for transmission.
- busy  output  1  high from an address match until STOP.
- nack_sent  output  1  one-cycle pulse when the target NACKs a pointer byte.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, pointer 0, regfile all 0x00, SDA released.
  - Synchronisers held at 1.
  - All outputs 0 except reg_rd_data, which follows the regfile.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchroniser plus one delay flop.
  - scl_rise/scl_fall and START/STOP are detected on the synchronised signals.
  - START = SDA falling while SCL high; STOP = SDA rising while SCL high.
  - Data is sampled only on scl_rise, using synchronised SDA.
- SDA drive timing:
  - Drive changes take effect on the cycle after scl_fall.
  - The drive is held through the following scl_fall.
- STOP: from any state -> IDLE next cycle; busy clears; pointer is retained.
  - STOP is ignored while this block is itself driving SDA low.
- START (incl. repeated START): from any state -> ADDR; bit counter reset to 7.
- States and transitions:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits MSB first.
    - Match (addr[7:1]==MY_ADDR): -> ADDR_ACK and raise busy.
    - Mismatch: -> IDLE, SDA stays released (no ACK).
  - ADDR_ACK: drive 0 for the 9th clock.
    - R/W=0 -> PTR.
    - R/W=1 -> load shift reg from regfile[pointer], pulse rd_strobe -> RDATA.
  - PTR: receive 8 bits -> PTR_ACK.
    - Value < NUM_REGS: ACK, set pointer.
    - Otherwise: NACK (release), pulse nack_sent, pointer unchanged, -> IDLE after the 9th clock.
  - PTR_ACK -> WDATA.
  - WDATA: receive 8 bits.
    - On the 8th scl_rise, write regfile[pointer] and pulse wr_strobe with wr_addr=pointer, wr_data=byte.
    - Increment pointer modulo NUM_REGS -> WDATA_ACK.
  - WDATA_ACK: ACK -> WDATA (burst continues).
  - RDATA: shift out 8 bits MSB first -> MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): pointer += 1 mod NUM_REGS, reload, pulse rd_strobe -> RDATA.
    - 1 (NACK): release SDA, -> IDLE wait (STOP/START expected).
- Combined write-pointer/repeated-START/read sequence: the pointer set in PTR is the read start address.
- Host port:
  - host_we writes regfile[host_addr] at the clock edge.
  - If it collides with a bus commit to the same index in the same cycle, the bus write wins.
  - A host write to the register currently in the TX shift register does not alter the byte in flight.
- Wrap: pointer NUM_REGS-1 increments to 0 on both write and read bursts.
- Reset mid-transfer: SDA is released immediately (async); the bus is then ignored until the next START.

Test Plan:
- Write burst: START, 0x02(addr 1,W), ptr 0x03, data 0xA5,0x5A, STOP -> ACK on all 4 bytes; wr_strobe x2 with (3,0xA5),(4,0x5A); reg_rd_data at 3/4 = A5/5A.
- Pointer + repeated START read: preload regs 6,7,0 = 11,22,33 via host; START 0x02, ptr 6, Sr, 0x03, read 3 bytes ACK,ACK,NACK -> bus sees 0x11,0x22,0x33 (wrap 7->0); rd_strobe x3.
- Address mismatch: START, 0x04, 1 data byte -> SDA never driven low; busy stays 0; no strobes.
- Bad pointer (NUM_REGS=8): START 0x02, ptr 0x09 -> 9th bit NACK, nack_sent pulse, pointer unchanged, next data byte not written.
- Collision: host_we to reg 2 with 0x77 in the same cycle as bus commit 0x99 to reg 2 -> reg 2 = 0x99.
- Reset mid-read: rst_n low during RDATA bit 4 -> SDA released within the same cycle; outputs zeroed; next full transaction completes normally.

Source files
------------

// File: rtl/i2c_subordinate_regfile.sv
// -----------------------------------------------------------------------------
// i2c_subordinate_regfile
//   I2C target with an internal NUM_REGS x 8 register file. The bus controller
//   writes a register pointer, then bursts data in (auto-increment), or issues
//   a repeated START and bursts data out from the pointer onwards. The host
//   side can load registers directly and read any register combinationally.
//
// Ports
//   clk_400, rst_n        : system clock (rising edge), async active-low reset
//   SCL, SDA              : bus pins; SDA is open-drain (0 or Z only)
//   host_we/addr/wdata    : host write port into the register file
//   reg_rd_addr/data      : host combinational read port
//   wr_strobe/addr/data   : pulse per bus-written byte committed to the file
//   rd_strobe             : pulse per register loaded for transmission
//   busy                  : address matched, until STOP
//   nack_sent             : pulse when an out-of-range pointer byte is NACKed
// -----------------------------------------------------------------------------
module i2c_subordinate_regfile #(
    parameter logic [6:0] MY_ADDR  = 7'h01,
    parameter int         NUM_REGS = 8,
    localparam int        AW       = $clog2(NUM_REGS)
) (
    input  logic          clk_400,
    input  logic          rst_n,
    input  logic          SCL,
    inout  wire           SDA,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    input  logic [AW-1:0] reg_rd_addr,
    output logic [7:0]    reg_rd_data,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_strobe,
    output logic          busy,
    output logic          nack_sent
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
    } state_e;

    // [0],[1] synchroniser, [2] delay flop for edge detection
    logic [2:0] scl_q, sda_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, rd_stb_q, nack_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;

    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    rx_byte;
    logic          bus_we, rd_ld, nack_d;
    logic          rx_in_range, sh_in_range;

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], SCL};
            sda_q <= {sda_q[1:0], SDA};
        end
    end

    assign scl_s     = scl_q[1];
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    // Our own release never happens with SCL high, but never let our drive
    // pattern be mistaken for a STOP.
    assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2] & ~oe_q;

    // Byte as it stands after shifting in the bit sampled on this scl_rise
    assign rx_byte     = {sh_q[6:0], sda_s};
    assign rx_in_range = ({1'b0, rx_byte} < 9'(NUM_REGS));
    assign sh_in_range = ({1'b0, sh_q} < 9'(NUM_REGS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        bus_we  = 1'b0;
        rd_ld   = 1'b0;
        nack_d  = 1'b0;

        if (start_det) begin
            state_d = ADDR;
            cnt_d   = 3'd7;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            // Drive changes are only made on scl_fall, so they land while SCL
            // is low and hold through the next falling edge.
            unique case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        if (rx_byte[7:1] == MY_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d = 3'd7;
                        if (sh_q[0]) begin
                            rd_ld   = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        sh_d  = rx_byte;
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            state_d = PTR_ACK;
                            if (rx_in_range) ptr_d  = rx_byte[AW-1:0];
                            else             nack_d = 1'b1;
                        end
                    end
                end
                PTR_ACK: begin
                    // sh_q still holds the pointer byte: ACK only if in range
                    if (scl_fall) oe_d = sh_in_range;
                    if (scl_rise) begin
                        cnt_d   = 3'd7;
                        state_d = sh_in_range ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        sh_d  = rx_byte;
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            bus_we  = 1'b1;
                            ptr_d   = ptr_q + AW'(1);
                            state_d = WDATA_ACK;
                        end
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d   = 3'd7;
                        state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) oe_d = ~tx_q[7];
                    if (scl_rise) begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) state_d = MACK;
                    end
                end
                MACK: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_q + AW'(1);
                            rd_ld   = 1'b1;
                            cnt_d   = 3'd7;
                            state_d = RDATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // TX byte is a private copy, so later host writes cannot disturb it
        if (rd_ld) tx_d = regs_q[ptr_d];
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd7;
            sh_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            nack_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= bus_we;
            rd_stb_q  <= rd_ld;
            nack_q    <= nack_d;
            if (bus_we) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_byte;
            end
        end
    end

    // Bus commit is applied last so it wins over a same-cycle host write
    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (host_we) regs_q[host_addr] <= host_wdata;
            if (bus_we)  regs_q[ptr_q]     <= rx_byte;
        end
    end

    assign SDA         = oe_q ? 1'b0 : 1'bz;
    assign reg_rd_data = regs_q[reg_rd_addr];
    assign wr_strobe   = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_strobe   = rd_stb_q;
    assign busy        = busy_q;
    assign nack_sent   = nack_q;

    // scl_s is kept for readability of the edge/condition equations above
    logic unused_scl_s;
    assign unused_scl_s = scl_s;

endmodule

// File: tb/tb_i2c_subordinate_regfile.sv
module tb_i2c_subordinate_regfile;
  localparam int         NR  = 8;
  localparam int         AW  = 3;
  localparam logic [6:0] MYA = 7'h01;
  localparam int         H   = 10;

  logic          clk_400 = 1'b0;
  logic          rst_n = 1'b0;
  logic          SCL = 1'b1;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic [AW-1:0] reg_rd_addr = '0;
  logic [7:0]    reg_rd_data, wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_strobe, rd_strobe, busy, nack_sent;
  logic          tb_sda_low = 1'b0;
  wire           SDA;

  assign SDA = tb_sda_low ? 1'b0 : 1'bz;
  pullup (SDA);

  i2c_subordinate_regfile #(.MY_ADDR(MYA), .NUM_REGS(NR)) dut (
    .clk_400(clk_400), .rst_n(rst_n), .SCL(SCL), .SDA(SDA),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .busy(busy), .nack_sent(nack_sent)
  );

  always #5 clk_400 = ~clk_400;

  // Behavioural model: register contents, pointer, busy, expected events
  logic [7:0]      m_regs [NR];
  int              m_ptr;
  bit              m_busy;
  logic [AW+7:0]   exp_wq [$];
  int              rd_cnt, exp_rd, nack_cnt, exp_nack;
  int              checks, fails;
  bit              quiet, dut_silent;
  logic [7:0]      wdat [8];
  logic [7:0]      rdat [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare process
  initial forever begin
    @(negedge clk_400);
    if (rst_n) begin
      if (wr_strobe) begin
        if (exp_wq.size() == 0) chk("wr_strobe_unexpected", 32'(wr_strobe), 32'(0));
        else chk("wr_commit", 32'({wr_addr, wr_data}), 32'(exp_wq.pop_front()));
      end
      if (rd_strobe) rd_cnt++;
      if (nack_sent) nack_cnt++;
      if (quiet) chk("reg_rd_data", 32'(reg_rd_data), 32'(m_regs[reg_rd_addr]));
      if (dut_silent) chk("sda_released", 32'(SDA === 1'b0 && !tb_sda_low), 32'(0));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_400); #1; end
  endtask

  task automatic bus_start();
    tb_sda_low = 1'b0; tick(H); SCL = 1'b1; tick(H);
    tb_sda_low = 1'b1; tick(H); SCL = 1'b0; tick(H);
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; tick(H); SCL = 1'b1; tick(H);
    tb_sda_low = 1'b0; tick(H);
  endtask

  task automatic wbit(input bit b);
    tb_sda_low = !b; tick(H); SCL = 1'b1; tick(H); SCL = 1'b0; tick(2);
  endtask

  task automatic rbit(output bit b);
    tb_sda_low = 1'b0; tick(H); SCL = 1'b1; tick(H/2);
    b = (SDA !== 1'b0); tick(H/2); SCL = 1'b0; tick(2);
  endtask

  // hcol: pulse host_we on the exact edge where the last bit is committed
  task automatic wbyte(input logic [7:0] d, input bit hcol, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && hcol) begin
        tb_sda_low = !d[0]; tick(H); SCL = 1'b1;
        tick(2); host_we = 1'b1; tick(1); host_we = 1'b0;
        tick(H-3); SCL = 1'b0; tick(2);
      end else wbit(d[i]);
    end
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input bit nack);
    bit bb;
    d = '0;
    for (int i = 0; i < 8; i++) begin rbit(bb); d = {d[6:0], bb}; end
    wbit(nack);
  endtask

  task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input int n, input bit hcol);
    bit ack, match, ok;
    match = (a == MYA);
    bus_start();
    wbyte({a, 1'b0}, 1'b0, ack);
    chk("addr_ack", 32'(ack), 32'(!match));
    if (match) m_busy = 1'b1;
    chk("busy", 32'(busy), 32'(m_busy));
    wbyte(p, 1'b0, ack);
    ok = match && (p < NR);
    chk("ptr_ack", 32'(ack), 32'(!ok));
    if (ok) m_ptr = int'(p);
    else if (match) exp_nack++;
    for (int i = 0; i < n; i++) begin
      if (ok) begin
        exp_wq.push_back({AW'(m_ptr), wdat[i]});
        m_regs[m_ptr] = wdat[i];
        m_ptr = (m_ptr + 1) % NR;
      end
      wbyte(wdat[i], hcol && (i == n-1), ack);
      chk("data_ack", 32'(ack), 32'(!ok));
    end
  endtask

  task automatic tx_read(input logic [6:0] a, input int n);
    bit ack, match;
    logic [7:0] b;
    match = (a == MYA);
    bus_start();
    wbyte({a, 1'b1}, 1'b0, ack);
    chk("raddr_ack", 32'(ack), 32'(!match));
    if (match) begin
      m_busy = 1'b1;
      for (int i = 0; i < n; i++) begin
        rbyte(b, i == n-1);
        rdat[i] = b;
        chk("rdata", 32'(b), 32'(m_regs[m_ptr]));
        exp_rd++;
        if (i != n-1) m_ptr = (m_ptr + 1) % NR;
      end
    end
  endtask

  task automatic sweep();
    quiet = 1'b1;
    for (int i = 0; i < NR; i++) begin reg_rd_addr = AW'(i); tick(1); end
    quiet = 1'b0;
  endtask

  task automatic tx_end();
    bus_stop();
    m_busy = 1'b0;
    tick(4);
    chk("busy_after_stop", 32'(busy), 32'(m_busy));
    chk("rd_strobe_count", 32'(rd_cnt), 32'(exp_rd));
    chk("nack_sent_count", 32'(nack_cnt), 32'(exp_nack));
    chk("wr_queue_drained", 32'(exp_wq.size()), 32'(0));
    sweep();
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1; tick(1);
    host_we = 1'b0; m_regs[a] = d;
  endtask

  initial begin
    bit ack, bb;
    logic [7:0] p;
    logic [6:0] a;
    int n, k;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ptr = 0; m_busy = 1'b0;
    checks = 0; fails = 0; rd_cnt = 0; exp_rd = 0; nack_cnt = 0; exp_nack = 0;
    quiet = 1'b0; dut_silent = 1'b0;

    tick(3);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_strobe", 32'(wr_strobe), 32'(0));
    chk("rst_rd_strobe", 32'(rd_strobe), 32'(0));
    chk("rst_nack_sent", 32'(nack_sent), 32'(0));
    chk("rst_sda", 32'(SDA === 1'b0), 32'(0));
    chk("rst_reg_rd_data", 32'(reg_rd_data), 32'(8'h00));
    rst_n = 1'b1; tick(5);
    sweep();

    // Write burst to pointer 3
    wdat[0] = 8'hA5; wdat[1] = 8'h5A;
    tx_write(MYA, 8'h03, 2, 1'b0); tx_end();
    reg_rd_addr = 3'd3; tick(1); chk("lit_reg3", 32'(reg_rd_data), 32'(8'hA5));
    reg_rd_addr = 3'd4; tick(1); chk("lit_reg4", 32'(reg_rd_data), 32'(8'h5A));

    // Pointer write, repeated START, read with wrap 7 -> 0
    host_wr(3'd6, 8'h11); host_wr(3'd7, 8'h22); host_wr(3'd0, 8'h33);
    tx_write(MYA, 8'h06, 0, 1'b0); tx_read(MYA, 3); tx_end();
    chk("lit_rd0", 32'(rdat[0]), 32'(8'h11));
    chk("lit_rd1", 32'(rdat[1]), 32'(8'h22));
    chk("lit_rd2", 32'(rdat[2]), 32'(8'h33));
    chk("lit_rd_cnt", 32'(rd_cnt), 32'(3));

    // Address mismatch: SDA must never be pulled by the target
    dut_silent = 1'b1;
    tx_write(7'h02, 8'h3C, 0, 1'b0); tx_end();
    dut_silent = 1'b0;

    // Bad pointer: NACK, pointer unchanged (still 0), data not written
    wdat[0] = 8'hEE;
    tx_write(MYA, 8'h09, 1, 1'b0); tx_end();
    chk("lit_nack_cnt", 32'(nack_cnt), 32'(1));
    tx_read(MYA, 1); tx_end();
    chk("lit_ptr_kept", 32'(rdat[0]), 32'(8'h33));

    // Host/bus collision on register 2: bus wins
    host_addr = 3'd2; host_wdata = 8'h77; wdat[0] = 8'h99;
    tx_write(MYA, 8'h02, 1, 1'b1); tx_end();
    reg_rd_addr = 3'd2; tick(1); chk("lit_collision", 32'(reg_rd_data), 32'(8'h99));

    // Randomised traffic
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? 7'h05 : MYA;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
      p = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      case (k)
        0: begin tx_write(a, p, n, 1'b0); tx_end(); end
        1: begin tx_write(a, p, 0, 1'b0); tx_read(a, n); tx_end(); end
        2: begin host_wr(AW'($urandom), 8'($urandom)); sweep(); end
        default: begin tx_read(a, n); tx_end(); end
      endcase
    end

    // Reset in the middle of a read of an all-zero register
    host_wr(3'd5, 8'h00);
    tx_write(MYA, 8'h05, 0, 1'b0);
    bus_start();
    wbyte({MYA, 1'b1}, 1'b0, ack);
    chk("mr_addr_ack", 32'(ack), 32'(0));
    exp_rd++;
    for (int i = 0; i < 3; i++) rbit(bb);
    tb_sda_low = 1'b0; tick(H); SCL = 1'b1; tick(H/2);
    chk("mr_driving_bit", 32'(SDA === 1'b0), 32'(1));
    rst_n = 1'b0; #1;
    chk("mr_sda_released", 32'(SDA === 1'b0), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_rd_strobe", 32'(rd_strobe), 32'(0));
    chk("mr_wr_strobe", 32'(wr_strobe), 32'(0));
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ptr = 0; m_busy = 1'b0;
    tick(3); rst_n = 1'b1; tick(3);
    SCL = 1'b0; tick(H);
    tx_end();
    wdat[0] = 8'hC3; wdat[1] = 8'h3C;
    tx_write(MYA, 8'h01, 2, 1'b0); tx_end();
    tx_write(MYA, 8'h01, 0, 1'b0); tx_read(MYA, 2); tx_end();
    chk("lit_after_rst0", 32'(rdat[0]), 32'(8'hC3));
    chk("lit_after_rst1", 32'(rdat[1]), 32'(8'h3C));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
